// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control pipeline.
//   - opcode constants for the 16-bit ISA (OP_ADD .. OP_HALT)
//   - ImmSrc encodings
//   - ctrl_t: control bundle carried from ID into EX
//   - mem_ctrl_t: the subset of controls that survives into MEM
//   - state_t: HALT drain state machine encoding
//   - helpers telling which source-register fields an opcode reads
package ctrl_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHIFT = 4'd5;
  localparam logic [3:0] OP_ADDI  = 4'd6;
  localparam logic [3:0] OP_LOAD  = 4'd7;
  localparam logic [3:0] OP_STORE = 4'd8;
  localparam logic [3:0] OP_BEQ   = 4'd9;
  localparam logic [3:0] OP_BNE   = 4'd10;
  localparam logic [3:0] OP_JUMP  = 4'd11;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [1:0] IMM_NONE = 2'b00;
  localparam logic [1:0] IMM_I    = 2'b01;
  localparam logic [1:0] IMM_B    = 2'b10;
  localparam logic [1:0] IMM_J    = 2'b11;

  typedef struct packed {
    logic       ALUsrc;
    logic [3:0] opcode;
    logic       dir;
    logic       MemRead;
    logic       MemWrite;
    logic       ResultSrc;
    logic       RegWrite;
    logic       is_branch;
    logic       is_bne;
    logic [7:0] imm;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic MemRead;
    logic MemWrite;
    logic ResultSrc;
    logic RegWrite;
  } mem_ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // rs1 is read by every ALU, memory and branch instruction.
  function automatic logic uses_rs1(input logic [3:0] op);
    return (op <= OP_BNE);
  endfunction

  // rs2 is read by register-register ALU ops, STORE (data) and branches.
  function automatic logic uses_rs2(input logic [3:0] op);
    return (op <= OP_SHIFT) || (op == OP_STORE) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: purely combinational instruction decoder.
// Ports:
//   instruction  in  16  [15:12] opcode, [7:0] imm/target, [0] shift dir
//   ctrl         out     control bundle for the ID->EX register
//   imm_src      out 2   immediate format used in ID
//   is_jump      out 1   instruction is JUMP
//   is_halt      out 1   instruction is HALT
// NOP (12-14) and HALT produce an all-zero control bundle.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [15:0] instruction,
  output ctrl_t       ctrl,
  output logic [1:0]  imm_src,
  output logic        is_jump,
  output logic        is_halt
);

  logic [3:0] op;
  // Register-number fields are consumed by the hazard logic, not here.
  logic       unused_reg_fields;

  assign op                = instruction[15:12];
  assign unused_reg_fields = ^instruction[11:8];

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    imm_src = IMM_NONE;
    is_jump = 1'b0;
    is_halt = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        ctrl.opcode   = op;
        ctrl.RegWrite = 1'b1;
      end
      OP_SHIFT: begin
        ctrl.opcode   = op;
        ctrl.dir      = instruction[0];
        ctrl.RegWrite = 1'b1;
      end
      OP_ADDI: begin
        ctrl.ALUsrc   = 1'b1;
        ctrl.opcode   = OP_ADD;
        ctrl.RegWrite = 1'b1;
        imm_src       = IMM_I;
      end
      OP_LOAD: begin
        ctrl.ALUsrc    = 1'b1;
        ctrl.opcode    = OP_ADD;   // address = rs1 + imm
        ctrl.MemRead   = 1'b1;
        ctrl.ResultSrc = 1'b1;
        ctrl.RegWrite  = 1'b1;
        imm_src        = IMM_I;
      end
      OP_STORE: begin
        ctrl.ALUsrc   = 1'b1;
        ctrl.opcode   = OP_ADD;
        ctrl.MemWrite = 1'b1;
        imm_src       = IMM_I;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.opcode    = OP_SUB;   // compare by subtraction in EX
        ctrl.is_branch = 1'b1;
        ctrl.is_bne    = (op == OP_BNE);
        ctrl.imm       = instruction[7:0];
        imm_src        = IMM_B;
      end
      OP_JUMP: begin
        imm_src = IMM_J;
        is_jump = 1'b1;
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_pipeline.sv
// control_pipeline: decode and control sequencing for datapath_pipelined.
// Decodes the IF instruction, carries controls through ID/EX, EX/MEM and
// MEM/WB, detects load-use hazards, squashes on flush/taken branch,
// generates jump/branch redirects and runs the HALT drain state machine.
// Optional feature macro: CTRL_PERF_CNT_EN adds cycle/stall/flush counters.
// Ports:
//   clk, reset (synchronous, active-high)
//   instruction_IF[15:0], branch_taken_EX, flush            inputs
//   stall, jump, PC_sel, branch_target[PC_W-1:0]            redirect / freeze
//   ImmSrc[1:0] (ID, combinational)                         ID control
//   ALUsrc, opcode[3:0], dir                                EX controls
//   MemRead_MEM, MemWrite_MEM, ResultSrc_MEM, RegWrite_MEM  MEM controls
//   RegWrite_WB, halted                                     WB / status
//   cycle_cnt, stall_cnt, flush_cnt [15:0]                  only with macro
module control_pipeline
  import ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int PC_W         = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     instruction_IF,
  input  logic            branch_taken_EX,
  input  logic            flush,
  output logic            stall,
  output logic            jump,
  output logic            PC_sel,
  output logic [PC_W-1:0] branch_target,
  output logic [1:0]      ImmSrc,
  output logic            ALUsrc,
  output logic [3:0]      opcode,
  output logic            dir,
  output logic            MemRead_MEM,
  output logic            MemWrite_MEM,
  output logic            ResultSrc_MEM,
  output logic            RegWrite_MEM,
  output logic            RegWrite_WB,
  output logic            halted
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0]     cycle_cnt,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
`endif
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  // Decode of the instruction currently in ID
  ctrl_t      dec_ctrl;
  logic [1:0] dec_imm_src;
  logic       dec_is_jump;
  logic       dec_is_halt;

  logic [3:0] op_id;
  logic [2:0] rd_id, rs1_id, rs2_id;

  // Pipeline and FSM state
  ctrl_t      ex_q, ex_d;
  logic [2:0] rd_ex_q, rd_ex_d;
  mem_ctrl_t  mem_q, mem_d;
  logic       rw_wb_q, rw_wb_d;
  state_t     state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic       halted_q, halted_d;

  // Hazard / redirect terms
  logic running;
  logic pc_sel_c;
  logic squash;
  logic load_use;
  logic jump_c;
  logic halt_go;

  // BNE vs BEQ is resolved by Execute through branch_taken_EX.
  logic unused_is_bne;
  assign unused_is_bne = ex_q.is_bne;

  ctrl_decoder u_dec (
    .instruction (instruction_IF),
    .ctrl        (dec_ctrl),
    .imm_src     (dec_imm_src),
    .is_jump     (dec_is_jump),
    .is_halt     (dec_is_halt)
  );

  assign op_id  = instruction_IF[15:12];
  assign rd_id  = instruction_IF[11:9];
  assign rs1_id = instruction_IF[8:6];
  assign rs2_id = instruction_IF[5:3];

  always_comb begin
    running  = (state_q == ST_RUN);
    pc_sel_c = running && ex_q.is_branch && branch_taken_EX;
    // Anything in ID on a flush or taken-branch cycle is wrong-path.
    squash   = flush || pc_sel_c;
    // A squashed instruction never needs the load result, so no stall.
    load_use = running && ex_q.MemRead && !squash &&
               ((uses_rs1(op_id) && (rd_ex_q == rs1_id)) ||
                (uses_rs2(op_id) && (rd_ex_q == rs2_id)));
    jump_c   = running && dec_is_jump && !load_use && !squash;
    halt_go  = running && dec_is_halt && !squash;
  end

  // Next-state for the pipeline registers and the HALT FSM
  always_comb begin
    ex_d        = dec_ctrl;
    rd_ex_d     = rd_id;
    mem_d       = '{MemRead:   ex_q.MemRead,
                    MemWrite:  ex_q.MemWrite,
                    ResultSrc: ex_q.ResultSrc,
                    RegWrite:  ex_q.RegWrite};
    rw_wb_d     = mem_q.RegWrite;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;

    if (!running || squash || load_use) begin
      ex_d    = CTRL_BUBBLE;
      rd_ex_d = '0;
    end

    case (state_q)
      ST_RUN: begin
        if (halt_go) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        // flush is deliberately not consulted: the drain always completes.
        if (drain_cnt_q == '0) state_d = ST_HALTED;
        else                   drain_cnt_d = drain_cnt_q - CNT_W'(1);
      end
      ST_HALTED: begin
        mem_d   = '0;
        rw_wb_d = 1'b0;
      end
      default: state_d = ST_RUN;
    endcase

    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= CTRL_BUBBLE;
      rd_ex_q     <= '0;
      mem_q       <= '0;
      rw_wb_q     <= 1'b0;
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      ex_q        <= ex_d;
      rd_ex_q     <= rd_ex_d;
      mem_q       <= mem_d;
      rw_wb_q     <= rw_wb_d;
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

  // Outputs
  always_comb begin
    stall  = load_use || !running;
    jump   = jump_c;
    PC_sel = pc_sel_c;
    if (pc_sel_c)    branch_target = PC_W'(ex_q.imm);
    else if (jump_c) branch_target = PC_W'(instruction_IF[7:0]);
    else             branch_target = '0;
    ImmSrc = (state_q == ST_HALTED) ? IMM_NONE : dec_imm_src;
  end

  assign ALUsrc        = ex_q.ALUsrc;
  assign opcode        = ex_q.opcode;
  assign dir           = ex_q.dir;
  assign MemRead_MEM   = mem_q.MemRead;
  assign MemWrite_MEM  = mem_q.MemWrite;
  assign ResultSrc_MEM = mem_q.ResultSrc;
  assign RegWrite_MEM  = mem_q.RegWrite;
  assign RegWrite_WB   = rw_wb_q;
  assign halted        = halted_q;

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // All three wrap naturally at 16 bits.
  always_comb begin
    cycle_cnt_d = (state_q != ST_HALTED) ? cycle_cnt_q + 16'd1 : cycle_cnt_q;
    stall_cnt_d = load_use ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (flush || pc_sel_c) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
